uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
- Transmit-side FIFO that sits directly upstream of the UART transmitter.
- Accepts bytes from a producer (CPU or control FSM) in bursts. Drains them one at a time to the UART through its send_req/tx_ready handshake, presenting each byte on the UART d_in.
- Decouples producer burst rate from the serial line rate. Reports occupancy and overflow.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width
DATA_SIZE, 8, byte width; must match the UART d_in width

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
wr_en  input  1  producer push strobe, one byte per cycle
wr_data  input  DATA_SIZE  byte to push
wr_ready  output  1  1 = FIFO not full
flush  input  1  discard all buffered bytes
ovf_clr  input  1  clear sticky overflow flag
tx_ready  input  1  from UART; 1 = transmitter idle and able to accept a byte
send_req  output  1  to UART; single-cycle request to transmit tx_data
tx_data  output  DATA_SIZE  to UART d_in; valid and stable while send_req = 1
count  output  ADDR_W+1  number of buffered bytes, 0..DEPTH
empty  output  1  count == 0
overflow  output  1  sticky; push attempted while full

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - send_req = 0, tx_data = 0, count = 0, empty = 1, wr_ready = 1, overflow = 0.
  - Pointers are zeroed and the FSM goes to IDLE.
  - Reset mid-transfer abandons any handshake. No send_req is issued in the cycle after reset releases.
- Storage:
  - Circular buffer with wr_ptr/rd_ptr of ADDR_W bits that wrap at DEPTH.
  - count is a separate ADDR_W+1 register, which disambiguates full from empty.
  - Memory contents are not reset.
- Push:
  - Accepted when wr_en = 1, count < DEPTH and flush = 0.
  - wr_ready = (count < DEPTH), taken from registered state.
  - A push while full is dropped, sets overflow, and leaves the FIFO unchanged. This holds even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if count > 0 and tx_ready = 1 and flush = 0, then on the next edge:
    - assert send_req for exactly one cycle;
    - load tx_data with the head entry;
    - pop (rd_ptr+1, count-1);
    - go to REQ.
  - REQ (send_req = 1): on the next edge, deassert send_req and go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_ready = 0, then go to IDLE. This stops a still-high tx_ready from triggering a double request.
- Handshake timing:
  - Latency from push into an empty FIFO, with tx_ready = 1, to send_req = 1 is 2 cycles: 1 cycle for count to update, 1 cycle for the IDLE decision.
  - tx_data holds its value after send_req drops, until the next request.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Flush:
  - Zeroes the pointers and count on the next edge.
  - Has priority over a same-cycle push; that push is discarded without setting overflow.
  - A byte already issued in REQ/WAIT_BUSY is not recalled; the FSM finishes its path normally.
  - Flush also clears overflow.
- ovf_clr clears overflow. A same-cycle overflow event wins, so overflow stays 1.

Test Plan:
- Reset, then idle with tx_ready = 1 -> send_req stays 0, count = 0, empty = 1, wr_ready = 1, tx_data = 0.
- Push 0xA5 with tx_ready = 1 -> send_req pulses exactly 1 cycle, 2 cycles after push, with tx_data = 0xA5.
  - Then hold tx_ready = 1 for 5 more cycles -> no second send_req.
  - Then drop tx_ready -> FSM returns to IDLE and count = 0.
- tx_ready = 0; push 0x00..0x0F (16 bytes) -> count = 16, wr_ready = 0.
  - A 17th push of 0xFF -> dropped and overflow = 1.
  - Model the UART (tx_ready drops 1 cycle after send_req, returns 10 cycles later) -> bytes 0x00..0x0F emitted in order, with 16 send_req pulses.
- Wrap-around: push 10 bytes, drain 10, push 12, drain 12 -> output order matches input order, count ends at 0.
- Simultaneous events:
  - FIFO with count = 3 while a send_req is issued and wr_en = 1 in the same cycle -> count stays 3.
  - flush together with wr_en -> count = 0, overflow = 0, pushed byte lost, the in-flight byte still completes.
- Assert rst_n = 0 while in WAIT_BUSY with count = 5 -> next cycle: count = 0, send_req = 0, FSM in IDLE.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// Transmit FIFO feeding the UART transmitter: buffers producer bursts and
// hands bytes one at a time to the UART via a single-cycle send_req pulse.
module uart_tx_buffer #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 flush,
    input  logic                 ovf_clr,
    input  logic                 tx_ready,
    output logic                 send_req,
    output logic [DATA_SIZE-1:0] tx_data,
    output logic [ADDR_W:0]      count,
    output logic                 empty,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_BUSY
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
    logic                 ovf_q, ovf_d;

    logic full;
    logic push;
    logic pop;

    assign full = (count_q == FULL_CNT);
    // Flush outranks a same-cycle push; a full FIFO drops the push even if a pop frees a slot.
    assign push = wr_en && !full && !flush;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((count_q != '0) && tx_ready && !flush) begin
                    pop     = 1'b1;
                    state_d = REQ;
                end
            end
            REQ:       state_d = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        ovf_d     = ovf_q;

        if (pop) begin
            tx_data_d = mem[rd_ptr_q];
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        if (flush) begin
            ovf_d = 1'b0;
        end else if (wr_en && full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign send_req = (state_q == REQ);
    assign tx_data  = tx_data_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: bytes queued on push are checked
// against tx_data on every send_req pulse, plus occupancy/flag checks.
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       flush;
    logic       ovf_clr;
    logic       tx_ready;
    logic       send_req;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic       empty;
    logic       overflow;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   pulses   = 0;
    logic prev_req = 1'b0;
    logic [7:0] sb [$];

    uart_tx_buffer #(.DEPTH(16), .ADDR_W(4), .DATA_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .tx_ready (tx_ready),
        .send_req (send_req),
        .tx_data  (tx_data),
        .count    (count),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit expect_out);
        wr_en   = 1'b1;
        wr_data = d;
        if (expect_out) sb.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    // UART model: tx_ready falls after each send_req and returns 10 cycles later.
    task automatic uart_drain(input int n);
        int got  = 0;
        int cyc  = 0;
        int hold = 0;
        tx_ready = 1'b1;
        while (got < n && cyc < n * 20) begin
            tick();
            cyc++;
            if (hold > 0) begin
                hold--;
                if (hold == 0) tx_ready = 1'b1;
            end else if (send_req) begin
                got++;
                tx_ready = 1'b0;
                hold     = 10;
            end
        end
        chk("drain_pulses", got, n);
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        if (send_req === 1'b1) begin
            pulses++;
            chk("send_req_single", prev_req, 1'b0);
            chk("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) chk("tx_data_order", tx_data, sb.pop_front());
        end
        prev_req = (send_req === 1'b1);
    end

    initial begin
        int p0;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
        ovf_clr = 1'b0; tx_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state, idle with tx_ready high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_send_req", send_req, 1'b0);
        end
        chk("rst_count", count, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_overflow", overflow, 1'b0);

        // Single byte: 2-cycle latency, one pulse only
        p0 = pulses;
        wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
        tick();
        wr_en = 1'b0;
        chk("lat_cnt1", count, 5'd1);
        chk("lat_req_early", send_req, 1'b0);
        tick();
        chk("lat_req", send_req, 1'b1);
        chk("lat_data", tx_data, 8'hA5);
        chk("lat_cnt0", count, 5'd0);
        tick();
        chk("req_drop", send_req, 1'b0);
        repeat (5) tick();
        chk("no_double_req", pulses - p0, 1);
        chk("tx_data_hold", tx_data, 8'hA5);
        tx_ready = 1'b0;
        tick();
        tick();
        chk("after_busy_count", count, 5'd0);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
        chk("full_count", count, 5'd16);
        chk("full_wr_ready", wr_ready, 1'b0);
        chk("full_no_ovf", overflow, 1'b0);
        push_byte(8'hFF, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", count, 5'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);
        p0 = pulses;
        uart_drain(16);
        chk("drain16_pulses", pulses - p0, 16);
        chk("drain16_count", count, 5'd0);
        chk("drain16_sb", sb.size(), 0);

        // Wrap-around
        for (int i = 0; i < 10; i++) push_byte(8'h20 + 8'(i), 1'b1);
        chk("wrap_cnt10", count, 5'd10);
        uart_drain(10);
        for (int i = 0; i < 12; i++) push_byte(8'h80 + 8'(i), 1'b1);
        chk("wrap_cnt12", count, 5'd12);
        uart_drain(12);
        chk("wrap_count", count, 5'd0);
        chk("wrap_sb", sb.size(), 0);

        // Push and pop in the same cycle
        push_byte(8'hB0, 1'b1);
        push_byte(8'hB1, 1'b1);
        push_byte(8'hB2, 1'b1);
        tx_ready = 1'b1; wr_en = 1'b1; wr_data = 8'hB3; sb.push_back(8'hB3);
        tick();
        wr_en = 1'b0; tx_ready = 1'b0;
        chk("pushpop_req", send_req, 1'b1);
        chk("pushpop_count", count, 5'd3);
        tick();
        tick();

        // Fill, overflow vs ovf_clr, full push with pop, then flush
        for (int i = 0; i < 13; i++) push_byte(8'h40 + 8'(i), 1'b1);
        chk("refill_count", count, 5'd16);
        push_byte(8'hF0, 1'b0);
        chk("ovf_set2", overflow, 1'b1);
        ovf_clr = 1'b1;
        push_byte(8'hF1, 1'b0);
        chk("ovf_wins_clr", overflow, 1'b1);
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr2", overflow, 1'b0);
        wr_en = 1'b1; wr_data = 8'h77; tx_ready = 1'b1;
        tick();
        chk("fullpop_req", send_req, 1'b1);
        chk("fullpop_count", count, 5'd15);
        chk("fullpop_ovf", overflow, 1'b1);
        flush = 1'b1; wr_data = 8'hEE; tx_ready = 1'b0;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        sb.delete();
        chk("flush_count", count, 5'd0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_ovf", overflow, 1'b0);
        chk("flush_inflight", tx_data, 8'hB1);
        tick();
        p0 = pulses;
        tx_ready = 1'b1;
        repeat (4) tick();
        chk("flush_no_req", pulses - p0, 0);
        chk("flush_count2", count, 5'd0);
        tx_ready = 1'b0;

        // Reset while in WAIT_BUSY
        for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i), 1'b1);
        tx_ready = 1'b1;
        tick();
        chk("wb_req", send_req, 1'b1);
        tick();
        chk("wb_count", count, 5'd5);
        chk("wb_req_low", send_req, 1'b0);
        rst_n = 1'b0;
        tick();
        sb.delete();
        chk("mid_rst_count", count, 5'd0);
        chk("mid_rst_req", send_req, 1'b0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", send_req, 1'b0);
        push_byte(8'h5A, 1'b1);
        chk("post_rst_early", send_req, 1'b0);
        tick();
        chk("post_rst_idle_req", send_req, 1'b1);
        tx_ready = 1'b0;
        tick();
        tick();
        chk("final_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
